// File: rtl/cmd_dispatcher_if.sv
// Bus bundle between the command dispatcher and its environment
// (uart_rx, uart_tx and the attached function units).
//
// Handshake semantics:
//   rx_ready  - level valid from uart_rx; rx_data is meaningful while it is high.
//               The byte is held for as long as rx_ready stays high, so the
//               dispatcher only rearms once rx_ready has returned low.
//   tx_start  - one-cycle request to uart_tx carrying tx_data; uart_tx reports
//               tx_active while the byte is on the wire.
//   unit_*    - unit_activate is a one-hot level that owns a unit for the
//               whole command; unit_done ends it.
interface cmd_dispatcher_if #(
  parameter int NUM_UNITS = 6
);
  logic [7:0]             rx_data;
  logic                   rx_ready;
  logic                   tx_active;
  logic [7:0]             tx_data;
  logic                   tx_start;
  logic [NUM_UNITS-1:0]   unit_activate;
  logic [NUM_UNITS-1:0]   unit_done;
  logic [NUM_UNITS*8-1:0] unit_tx_data;
  logic [NUM_UNITS-1:0]   unit_tx_start;
  logic [7:0]             state_code;
  logic                   busy;
  logic [7:0]             err_count;

  // Dispatcher side
  modport master (
    input  rx_data, rx_ready, tx_active, unit_done, unit_tx_data, unit_tx_start,
    output tx_data, tx_start, unit_activate, state_code, busy, err_count
  );

  // Environment side (uart, units, testbench)
  modport slave (
    output rx_data, rx_ready, tx_active, unit_done, unit_tx_data, unit_tx_start,
    input  tx_data, tx_start, unit_activate, state_code, busy, err_count
  );
endinterface

// File: rtl/cmd_dispatcher.sv
// UART command dispatcher: an opcode byte selects a function unit, the unit's
// tx stream is forwarded to the shared uart_tx until it signals done.
// Unknown opcodes get a NAK byte, stalled units a timeout byte; an abort byte
// cancels units that do not consume rx bytes themselves.
module cmd_dispatcher #(
  parameter int                     NUM_UNITS      = 6,
  parameter logic [NUM_UNITS*8-1:0] OPCODES        = {8'h24, 8'h23, 8'h72, 8'h71, 8'h22, 8'h21},
  parameter logic [NUM_UNITS-1:0]   RX_OWNER_MASK  = 6'b001100,
  parameter int unsigned            TIMEOUT_CYCLES = 0,
  parameter logic [7:0]             ABORT_CODE     = 8'h1B,
  parameter logic [7:0]             NAK_CODE       = 8'hEE,
  parameter logic [7:0]             TMO_CODE       = 8'hEF
) (
  input  logic             clk_50mhz,
  input  logic             reset,
  cmd_dispatcher_if.master bus
);

  // REPLY is split into three phases that all display as 0E.
  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_REPLY_SEND,
    S_REPLY_HI,
    S_REPLY_LO,
    S_SETTLE
  } state_t;

  state_t               state_q, state_d;
  logic [NUM_UNITS-1:0] activate_q, activate_d;
  logic [7:0]           tx_data_q, tx_data_d;
  logic                 tx_start_q, tx_start_d;
  logic [7:0]           err_count_q, err_count_d;
  logic [31:0]          tmo_cnt_q, tmo_cnt_d;

  logic                 match;
  logic [NUM_UNITS-1:0] match_vec;
  logic                 sel_done;
  logic                 sel_tx_start;
  logic [7:0]           sel_tx_data;
  logic [7:0]           sel_opcode;
  logic                 sel_owner;
  logic                 tmo_hit;
  logic                 abort_hit;

  // Opcode lookup (descending scan so the lowest matching index wins) and
  // selection of the active unit's inputs through the one-hot activate.
  always_comb begin
    match        = 1'b0;
    match_vec    = '0;
    sel_done     = 1'b0;
    sel_tx_start = 1'b0;
    sel_tx_data  = 8'h00;
    sel_opcode   = 8'h00;
    for (int i = NUM_UNITS - 1; i >= 0; i--) begin
      if (bus.rx_data == OPCODES[8*i +: 8]) begin
        match        = 1'b1;
        match_vec    = '0;
        match_vec[i] = 1'b1;
      end
    end
    for (int i = 0; i < NUM_UNITS; i++) begin
      if (activate_q[i]) begin
        sel_done     = bus.unit_done[i];
        sel_tx_start = bus.unit_tx_start[i];
        sel_tx_data  = bus.unit_tx_data[8*i +: 8];
        sel_opcode   = OPCODES[8*i +: 8];
      end
    end
    sel_owner = |(activate_q & RX_OWNER_MASK);
    tmo_hit   = (TIMEOUT_CYCLES != 0) && (tmo_cnt_q == TIMEOUT_CYCLES - 1);
    abort_hit = bus.rx_ready && (bus.rx_data == ABORT_CODE) && !sel_owner;
  end

  // State register
  always_ff @(posedge clk_50mhz or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; in RUN the order is done > timeout > abort
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:       if (bus.rx_ready) state_d = match ? S_RUN : S_REPLY_SEND;
      S_RUN: begin
        if (sel_done)       state_d = S_SETTLE;
        else if (tmo_hit)   state_d = S_REPLY_SEND;
        else if (abort_hit) state_d = S_SETTLE;
      end
      S_REPLY_SEND: if (!bus.tx_active) state_d = S_REPLY_HI;
      S_REPLY_HI:   if (bus.tx_active)  state_d = S_REPLY_LO;
      S_REPLY_LO:   if (!bus.tx_active) state_d = S_SETTLE;
      S_SETTLE:     if (!bus.rx_ready && !bus.tx_active) state_d = S_IDLE;
      default:      state_d = S_IDLE;
    endcase
  end

  // Datapath next values: activate, registered tx mux, reply byte, counters
  always_comb begin
    activate_d  = activate_q;
    tx_data_d   = tx_data_q;
    tx_start_d  = 1'b0;
    err_count_d = err_count_q;
    tmo_cnt_d   = (state_q == S_RUN) ? tmo_cnt_q + 32'd1 : 32'd0;

    if (state_q == S_IDLE && state_d == S_RUN) activate_d = match_vec;
    else if (state_d != S_RUN)                 activate_d = '0;

    if (state_q == S_RUN && state_d == S_RUN) begin
      tx_data_d  = sel_tx_data;
      tx_start_d = sel_tx_start;
    end

    if (state_d == S_REPLY_SEND && state_q != S_REPLY_SEND) begin
      tx_data_d = (state_q == S_RUN) ? TMO_CODE : NAK_CODE;
      if (err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
    end

    if (state_q == S_REPLY_SEND && state_d == S_REPLY_HI) tx_start_d = 1'b1;
  end

  // Datapath registers
  always_ff @(posedge clk_50mhz or negedge reset) begin
    if (!reset) begin
      activate_q  <= '0;
      tx_data_q   <= 8'h00;
      tx_start_q  <= 1'b0;
      err_count_q <= 8'h00;
      tmo_cnt_q   <= 32'd0;
    end else begin
      activate_q  <= activate_d;
      tx_data_q   <= tx_data_d;
      tx_start_q  <= tx_start_d;
      err_count_q <= err_count_d;
      tmo_cnt_q   <= tmo_cnt_d;
    end
  end

  // Outputs: display code follows the state register directly
  always_comb begin
    case (state_q)
      S_IDLE:                               bus.state_code = 8'h00;
      S_RUN:                                bus.state_code = sel_opcode;
      S_REPLY_SEND, S_REPLY_HI, S_REPLY_LO: bus.state_code = 8'h0E;
      S_SETTLE:                             bus.state_code = 8'h01;
      default:                              bus.state_code = 8'h00;
    endcase
    bus.busy          = (state_q != S_IDLE);
    bus.unit_activate = activate_q;
    bus.tx_data       = tx_data_q;
    bus.tx_start      = tx_start_q;
    bus.err_count     = err_count_q;
  end

endmodule

// File: tb/tb_cmd_dispatcher.sv
// Directed bench for cmd_dispatcher. Two instances share the stimulus:
// dut_a has no timeout, dut_b times out after 50 RUN cycles. Each has its
// own small uart_tx model that stays active for 10 cycles per start pulse.
module tb_cmd_dispatcher;

  localparam int NU = 6;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #10 clk = ~clk;

  // ---------------- stimulus signals ----------------
  logic [7:0]    rx_data = 8'h00;
  logic          rx_ready = 1'b0;
  logic [NU-1:0] unit_done = '0;
  logic [NU*8-1:0] unit_tx_data = '0;
  logic [NU-1:0] unit_tx_start = '0;

  cmd_dispatcher_if #(.NUM_UNITS(NU)) if_a ();
  cmd_dispatcher_if #(.NUM_UNITS(NU)) if_b ();

  int uart_cnt_a = 0;
  int uart_cnt_b = 0;

  assign if_a.rx_data       = rx_data;
  assign if_a.rx_ready      = rx_ready;
  assign if_a.unit_done     = unit_done;
  assign if_a.unit_tx_data  = unit_tx_data;
  assign if_a.unit_tx_start = unit_tx_start;
  assign if_a.tx_active     = (uart_cnt_a != 0);
  assign if_b.rx_data       = rx_data;
  assign if_b.rx_ready      = rx_ready;
  assign if_b.unit_done     = unit_done;
  assign if_b.unit_tx_data  = unit_tx_data;
  assign if_b.unit_tx_start = unit_tx_start;
  assign if_b.tx_active     = (uart_cnt_b != 0);

  cmd_dispatcher #(.NUM_UNITS(NU), .TIMEOUT_CYCLES(0)) dut_a (
    .clk_50mhz(clk), .reset(rst_n), .bus(if_a)
  );
  cmd_dispatcher #(.NUM_UNITS(NU), .TIMEOUT_CYCLES(50)) dut_b (
    .clk_50mhz(clk), .reset(rst_n), .bus(if_b)
  );

  // uart_tx models
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      uart_cnt_a <= 0;
      uart_cnt_b <= 0;
    end else begin
      if (uart_cnt_a != 0)    uart_cnt_a <= uart_cnt_a - 1;
      else if (if_a.tx_start) uart_cnt_a <= 10;
      if (uart_cnt_b != 0)    uart_cnt_b <= uart_cnt_b - 1;
      else if (if_b.tx_start) uart_cnt_b <= 10;
    end
  end

  // ---------------- monitor (capture only) ----------------
  logic [7:0] obs_q[$];
  int pulses_a = 0;
  int onehot_bad = 0;
  always @(posedge clk) begin
    if (if_a.tx_start) begin
      obs_q.push_back(if_a.tx_data);
      pulses_a <= pulses_a + 1;
    end
    if (!$onehot0(if_a.unit_activate) || !$onehot0(if_b.unit_activate))
      onehot_bad <= onehot_bad + 1;
  end

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q[$];
  int obs_rd = 0;
  int n_total = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic sb_drain(input string tag);
    check({tag, "_txcount"}, obs_q.size() - obs_rd, exp_q.size());
    while (exp_q.size() > 0 && obs_rd < obs_q.size()) begin
      check({tag, "_txbyte"}, obs_q[obs_rd], exp_q.pop_front());
      obs_rd++;
    end
    exp_q.delete();
    obs_rd = obs_q.size();
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    rx_data = 8'h00;
    rx_ready = 1'b0;
    unit_done = '0;
    unit_tx_data = '0;
    unit_tx_start = '0;
    tick(3);
    rst_n = 1'b1;
    tick(1);
  endtask

  task automatic wait_idle(input bit on_b, input string tag);
    int n;
    n = 0;
    while (((on_b ? if_b.state_code : if_a.state_code) != 8'h00) && n < 200) begin
      tick(1);
      n++;
    end
    check({tag, "_idle"}, on_b ? if_b.state_code : if_a.state_code, 8'h00);
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_ready = 1'b1;
  endtask

  // global time bound
  initial begin
    #1_500_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int p0;

    // reset state
    rst_n = 1'b0;
    tick(3);
    check("rst_state", if_a.state_code, 8'h00);
    check("rst_act", if_a.unit_activate, 6'b0);
    check("rst_txdata", if_a.tx_data, 8'h00);
    check("rst_txstart", if_a.tx_start, 1'b0);
    check("rst_err", if_a.err_count, 8'h00);
    check("rst_busy", if_a.busy, 1'b0);
    check("rst_b_state", if_b.state_code, 8'h00);
    rst_n = 1'b1;
    tick(1);

    // 1: opcode 0x22 -> unit1, forwarded tx, done after ~100 cycles
    exp_q.push_back(8'hA5);
    send_byte(8'h22);
    #1 check("t1_act_pre", if_a.unit_activate, 6'b000000);
    tick(1);
    check("t1_act", if_a.unit_activate, 6'b000010);
    check("t1_state", if_a.state_code, 8'h22);
    check("t1_busy", if_a.busy, 1'b1);
    rx_ready = 1'b0;
    unit_tx_data[15:8] = 8'hA5;
    unit_tx_start = 6'b000010;
    tick(1);
    check("t1_fwd_data", if_a.tx_data, 8'hA5);
    check("t1_fwd_start", if_a.tx_start, 1'b1);
    unit_tx_start = 6'b000001;
    unit_tx_data[7:0] = 8'h5A;
    tick(1);
    check("t1_inact_start", if_a.tx_start, 1'b0);
    check("t1_inact_data", if_a.tx_data, 8'hA5);
    unit_tx_start = '0;
    unit_done = 6'b111101;
    tick(1);
    check("t1_inact_done", if_a.state_code, 8'h22);
    check("t1_inact_act", if_a.unit_activate, 6'b000010);
    unit_done = '0;
    tick(96);
    unit_done = 6'b000010;
    tick(1);
    check("t1_settle", if_a.state_code, 8'h01);
    check("t1_act_off", if_a.unit_activate, 6'b000000);
    unit_done = '0;
    tick(1);
    check("t1_idle", if_a.state_code, 8'h00);
    check("t1_busy_off", if_a.busy, 1'b0);
    sb_drain("t1");

    // 2: unknown opcode -> NAK
    do_reset();
    p0 = pulses_a;
    exp_q.push_back(8'hEE);
    send_byte(8'h55);
    tick(1);
    check("t2_state", if_a.state_code, 8'h0E);
    check("t2_err", if_a.err_count, 8'h01);
    check("t2_txdata", if_a.tx_data, 8'hEE);
    check("t2_act", if_a.unit_activate, 6'b0);
    rx_ready = 1'b0;
    wait_idle(1'b0, "t2");
    check("t2_pulses", pulses_a - p0, 1);
    check("t2_err_end", if_a.err_count, 8'h01);
    check("t2_hold", if_a.tx_data, 8'hEE);
    sb_drain("t2");

    // 3: timeout after 50 RUN cycles on dut_b
    do_reset();
    send_byte(8'h21);
    tick(1);
    check("t3_act", if_b.unit_activate, 6'b000001);
    check("t3_state", if_b.state_code, 8'h21);
    rx_ready = 1'b0;
    tick(49);
    check("t3_act_50", if_b.unit_activate, 6'b000001);
    tick(1);
    check("t3_act_drop", if_b.unit_activate, 6'b000000);
    check("t3_reply", if_b.state_code, 8'h0E);
    check("t3_txdata", if_b.tx_data, 8'hEF);
    check("t3_err", if_b.err_count, 8'h01);
    wait_idle(1'b1, "t3");
    check("t3_err_end", if_b.err_count, 8'h01);

    // 4: abort on a plain unit, ignored for an rx-owner unit
    do_reset();
    send_byte(8'h21);
    tick(1);
    check("t4_act0", if_a.unit_activate, 6'b000001);
    rx_data = 8'h1B;
    tick(1);
    check("t4_abort_state", if_a.state_code, 8'h01);
    check("t4_abort_act", if_a.unit_activate, 6'b000000);
    tick(1);
    check("t4_held", if_a.state_code, 8'h01);
    rx_ready = 1'b0;
    tick(1);
    check("t4_idle", if_a.state_code, 8'h00);
    check("t4_err", if_a.err_count, 8'h00);
    send_byte(8'h71);
    tick(1);
    check("t4_act2", if_a.unit_activate, 6'b000100);
    rx_data = 8'h1B;
    tick(3);
    check("t4_owner_act", if_a.unit_activate, 6'b000100);
    check("t4_owner_state", if_a.state_code, 8'h71);
    rx_ready = 1'b0;
    unit_done = 6'b000100;
    tick(1);
    check("t4_done_settle", if_a.state_code, 8'h01);
    unit_done = '0;
    wait_idle(1'b0, "t4");

    // 5: done and timeout together on dut_b -> done wins
    do_reset();
    send_byte(8'h21);
    tick(1);
    rx_ready = 1'b0;
    tick(49);
    unit_done = 6'b000001;
    tick(1);
    check("t5_state", if_b.state_code, 8'h01);
    check("t5_act", if_b.unit_activate, 6'b0);
    check("t5_err", if_b.err_count, 8'h00);
    check("t5_txstart", if_b.tx_start, 1'b0);
    unit_done = '0;
    tick(1);
    check("t5_idle", if_b.state_code, 8'h00);

    // 6: async reset mid-RUN, then err_count saturation
    do_reset();
    send_byte(8'h22);
    tick(1);
    rx_ready = 1'b0;
    check("t6_act", if_a.unit_activate, 6'b000010);
    #5 rst_n = 1'b0;
    #1;
    check("t6_async_act", if_a.unit_activate, 6'b0);
    check("t6_async_state", if_a.state_code, 8'h00);
    check("t6_async_busy", if_a.busy, 1'b0);
    tick(1);
    rst_n = 1'b1;
    tick(1);
    for (int i = 0; i < 256; i++) begin
      exp_q.push_back(8'hEE);
      send_byte(8'h55);
      tick(1);
      rx_ready = 1'b0;
      wait_idle(1'b0, "t6_nak");
      if (i == 0)   check("t6_err_first", if_a.err_count, 8'h01);
      if (i == 254) check("t6_err_255", if_a.err_count, 8'hFF);
    end
    check("t6_err_sat", if_a.err_count, 8'hFF);
    sb_drain("t6");

    check("onehot", onehot_bad, 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
